dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single data-memory port between the pipeline MEM stage (core) and an external debug/loader requester (dbg). The core has fixed priority. A dbg access is granted on any cycle the core leaves the port idle. An optional anti-starvation counter forces a one-cycle core stall so that dbg cannot wait forever. The block sits between the EX/MEM pipeline register outputs and the data memory. Its `core_stall` output is ORed into the pipeline's PC/IF-ID/ID-EX/EX-MEM hold logic.

## Interface

Parameters:
- `DATA_W`, 32, data width
- `DM_ADDRESS`, 9, data-memory byte address width
- `MAX_WAIT`, 8, busy cycles dbg may wait before a forced steal; legal range ≥1

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `core_rd` in 1: MEM-stage read enable.
- `core_wr` in 1: MEM-stage write enable.
- `core_addr` in `DM_ADDRESS`: core address.
- `core_wdata` in `DATA_W`: core store data.
- `core_func3` in 3: core access size/sign.
- `core_rdata` out `DATA_W`: `mem_rdata` passed through, combinational.
- `core_stall` out 1: registered; freeze pipeline this cycle, core retries next cycle.
- `dbg_req` in 1: dbg request; held until granted.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_addr` in `DM_ADDRESS`: dbg address.
- `dbg_wdata` in `DATA_W`: dbg write data.
- `dbg_gnt` out 1: combinational; access performed this cycle.
- `dbg_rvalid` out 1: registered; read data valid.
- `dbg_rdata` out `DATA_W`: registered read data.
- `mem_rd`, `mem_wr` out 1: memory enables.
- `mem_addr` out `DM_ADDRESS`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_func3` out 3: memory access size/sign.
- `mem_rdata` in `DATA_W`: memory read data, same-cycle.

## Operation

- States: ARB_CORE (reset state) and ARB_STEAL.
- Core busy = `core_rd` | `core_wr`.
- In ARB_CORE:
  - `mem_*` is driven from the core inputs.
  - `dbg_gnt` = `dbg_req` & !busy.
  - When dbg is granted, `mem_*` is driven from dbg: `mem_rd`=!`dbg_we`, `mem_wr`=`dbg_we`, `mem_func3`=3'b010 (word access only).
- In ARB_STEAL:
  - `mem_*` is driven from dbg.
  - `dbg_gnt`=`dbg_req`.
  - `core_stall`=1; core requests are ignored.
- Wait counter `wait_cnt`, width $clog2(MAX_WAIT+1):
  - Increments when ARB_CORE & `dbg_req` & busy.
  - Clears on any `dbg_gnt`, or when `dbg_req`=0.
  - Never wraps.
- Transitions:
  - ARB_CORE→ARB_STEAL at the edge where `wait_cnt`==MAX_WAIT-1 and it would increment.
  - ARB_STEAL→ARB_CORE unconditionally after one cycle.
- `dbg_rvalid`/`dbg_rdata`:
  - On a granted dbg read, capture `mem_rdata` at the clock edge; `dbg_rvalid`=1 for exactly one cycle.
  - On a granted dbg write, `dbg_rvalid` stays 0.
  - `dbg_rdata` holds its last value otherwise.
- Handshake rule: `dbg_req` drops only in the cycle after `dbg_gnt`. Behaviour on early withdrawal: in ARB_STEAL with `dbg_req`=0, the memory sees no access (`mem_rd`=`mem_wr`=0), the stall is still taken, and the state returns to ARB_CORE.

## Timing

- Reset values: state ARB_CORE, `wait_cnt`=0, `core_stall`=0, `dbg_rvalid`=0, `dbg_rdata`=0.
- All `mem_*` outputs and `dbg_gnt` are combinational from current state and inputs, so they are 0/idle while `reset` is high.
- Idle-port grant latency: 0 cycles (grant in the same cycle as the request).
- Read-data latency: `dbg_rvalid` one cycle after `dbg_gnt`.
- Worst-case dbg latency with a continuously busy core: MAX_WAIT busy cycles, then grant in the ARB_STEAL cycle.
- Core and dbg requesting simultaneously with the counter below threshold: core wins, counter increments.
- Reset asserted mid-ARB_STEAL: state forced to ARB_CORE asynchronously. `core_stall` drops without waiting for a clock, and no pending `dbg_rvalid` is issued.
- Back-to-back dbg requests after a steal: the counter restarts from 0; steals are spaced at least MAX_WAIT+1 cycles apart.

## Configuration

- `DMEM_ARB_ANTISTARVE_EN` defined: wait counter and ARB_STEAL are present, as described above.
- Not defined: the counter and ARB_STEAL are removed; `core_stall` is tied 0; dbg is served only in core-idle cycles and may wait indefinitely.

## Structure

- Shared pipeline package holds:
  - `arb_state_t` enum {ARB_CORE, ARB_STEAL}
  - constant `DBG_FUNC3_WORD`=3'b010
- One sub-module, `dmem_arb_wait_ctr`: the saturating wait counter with a `steal` strobe output. It is instantiated only under `DMEM_ARB_ANTISTARVE_EN`.

## Test plan

- Idle core, dbg write addr 0x040 data 0xDEADBEEF, then read 0x040 → `dbg_gnt` in the same cycle as each request; `dbg_rvalid`=1 one cycle after the read grant with `dbg_rdata`=0xDEADBEEF; `core_stall` stays 0.
- Core and dbg requesting in the same cycle, core read of 0x010 → memory sees the core address, `dbg_gnt`=0, `wait_cnt`=1.
- Core busy every cycle, `dbg_req` held, MAX_WAIT=8 → ARB_STEAL in the 9th cycle, `core_stall`=1 for exactly 1 cycle with dbg granted; core retry is visible on the memory port the next cycle.
- MAX_WAIT=1, core continuously busy, dbg requests continuously → steals every 2nd cycle, never two in a row.
- Reset pulse asserted during ARB_STEAL (async, between edges) → `core_stall`=0 immediately, `dbg_rvalid` stays 0, state ARB_CORE after release.
- Built without `DMEM_ARB_ANTISTARVE_EN`, core busy for 50 cycles → `dbg_gnt`=0 and `core_stall`=0 throughout; dbg is granted in the first idle core cycle.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Arbiter states and the fixed access size used by the debug/loader requester.
package dmem_port_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_CORE  = 1'b0,
        ARB_STEAL = 1'b1
    } arb_state_t;

    localparam logic [2:0] DBG_FUNC3_WORD = 3'b010;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating count of busy cycles a pending dbg request has waited.
// Raises 'steal' on the cycle whose increment reaches MAX_WAIT.
module dmem_arb_wait_ctr #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic steal
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    assign steal = inc && (wait_cnt == CNT_LAST);

    // Clear wins over increment; the count parks at MAX_WAIT instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != CNT_TOP)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage (fixed priority) and a debug/loader port.
// Define DMEM_ARB_ANTISTARVE_EN to add the wait counter and the one-cycle ARB_STEAL core stall.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_func3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    arb_state_t state;
    logic       core_busy;

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("dmem_port_arbiter: MAX_WAIT must be at least 1");
    end

    assign core_busy  = core_rd | core_wr;
    assign core_rdata = mem_rdata;

`ifdef DMEM_ARB_ANTISTARVE_EN
    logic wait_inc;
    logic wait_clr;
    logic steal;

    assign wait_inc = (state == ARB_CORE) && dbg_req && core_busy;
    assign wait_clr = dbg_gnt || !dbg_req;

    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .steal (steal)
    );

    // A steal always lasts exactly one cycle, whether or not dbg is still asking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_CORE;
        end else if (state == ARB_STEAL) begin
            state <= ARB_CORE;
        end else if (steal) begin
            state <= ARB_STEAL;
        end
    end
`else
    assign state = ARB_CORE;
`endif

    assign core_stall = (state == ARB_STEAL);

    // Port mux; everything is held idle while reset is asserted.
    always_comb begin
        dbg_gnt   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_func3 = '0;
        if (!reset) begin
            if ((state == ARB_STEAL) || (dbg_req && !core_busy)) begin
                dbg_gnt   = dbg_req;
                mem_rd    = dbg_req && !dbg_we;
                mem_wr    = dbg_req && dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_func3 = DBG_FUNC3_WORD;
            end else begin
                mem_rd    = core_rd;
                mem_wr    = core_wr;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_func3 = core_func3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= dbg_gnt && !dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model; expectations follow DMEM_ARB_ANTISTARVE_EN.
module tb_dmem_port_arbiter;

    localparam int DATA_W     = 32;
    localparam int DM_ADDRESS = 9;
    localparam int MAX_WAIT   = 8;
`ifdef DMEM_ARB_ANTISTARVE_EN
    localparam bit ANTI = 1'b1;
`else
    localparam bit ANTI = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        core_rd, core_wr;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_func3;
    logic        dbg_req, dbg_we;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;

    logic [31:0] core_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic        core_stall, dbg_gnt, dbg_rvalid, mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [2:0]  mem_func3;

    logic [31:0] core_rdata1, dbg_rdata1, mem_wdata1, mem_rdata1;
    logic        core_stall1, dbg_gnt1, dbg_rvalid1, mem_rd1, mem_wr1;
    logic [8:0]  mem_addr1;
    logic [2:0]  mem_func31;

    // Reference memory: word-addressed, written only by the model's expected stores.
    logic [31:0] refMem [0:127];

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    bit          mSteal;
    int          mWait;
    bit          mRvalid;
    logic [31:0] mRdata;
    bit          mLastGnt;
    bit          obsGnt, obsStall;

    assign mem_rdata  = refMem[mem_addr[8:2]];
    assign mem_rdata1 = 32'h0;

    dmem_port_arbiter #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_func3(core_func3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    dmem_port_arbiter #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .MAX_WAIT(1)) dut1 (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_func3(core_func3),
        .core_rdata(core_rdata1), .core_stall(core_stall1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rdata(dbg_rdata1),
        .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_func3(mem_func31), .mem_rdata(mem_rdata1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic cr, input logic cw, input logic [8:0] ca,
                                 input logic [31:0] cwd, input logic [2:0] cf,
                                 input logic dr, input logic dw, input logic [8:0] da,
                                 input logic [31:0] dwd);
        core_rd    = cr;
        core_wr    = cw;
        core_addr  = ca;
        core_wdata = cwd;
        core_func3 = cf;
        dbg_req    = dr;
        dbg_we     = dw;
        dbg_addr   = da;
        dbg_wdata  = dwd;
    endtask

    task automatic modelReset();
        mSteal   = 1'b0;
        mWait    = 0;
        mRvalid  = 1'b0;
        mRdata   = 32'h0;
        mLastGnt = 1'b0;
    endtask

    // One clock cycle: predict, check at the falling edge, then advance the model after the rising edge.
    task automatic stepCycle();
        bit          busy, eGnt, eStall, eRd, eWr, dbgOwns, nextSteal;
        logic [8:0]  eAddr;
        logic [31:0] eWdata;
        logic [2:0]  eF3;
        busy    = core_rd | core_wr;
        eStall  = ANTI && mSteal;
        dbgOwns = eStall || (dbg_req && !busy);
        eGnt    = dbgOwns && dbg_req;
        eRd     = dbgOwns ? (dbg_req && !dbg_we) : core_rd;
        eWr     = dbgOwns ? (dbg_req && dbg_we) : core_wr;
        eAddr   = dbgOwns ? dbg_addr : core_addr;
        eWdata  = dbgOwns ? dbg_wdata : core_wdata;
        eF3     = dbgOwns ? 3'b010 : core_func3;
        @(negedge clk);
        obsGnt   = dbg_gnt;
        obsStall = core_stall;
        checkOutput("core_stall", core_stall, eStall);
        checkOutput("dbg_gnt", dbg_gnt, eGnt);
        checkOutput("mem_rd", mem_rd, eRd);
        checkOutput("mem_wr", mem_wr, eWr);
        if (eRd || eWr) begin
            checkOutput("mem_addr", mem_addr, eAddr);
            checkOutput("mem_func3", mem_func3, eF3);
        end
        if (eWr) checkOutput("mem_wdata", mem_wdata, eWdata);
        if (eRd) checkOutput("core_rdata", core_rdata, refMem[eAddr[8:2]]);
        checkOutput("dbg_rvalid", dbg_rvalid, mRvalid);
        checkOutput("dbg_rdata", dbg_rdata, mRdata);
        @(posedge clk);
        #1;
        mRvalid = eGnt && !dbg_we;
        if (mRvalid) mRdata = refMem[dbg_addr[8:2]];
        if (eWr) refMem[eAddr[8:2]] = eWdata;
        nextSteal = 1'b0;
        if (eGnt || !dbg_req) begin
            mWait = 0;
        end else if (!eStall && busy) begin
            mWait++;
            if (ANTI && mWait == MAX_WAIT) begin
                nextSteal = 1'b1;
                mWait     = 0;
            end
        end
        mSteal   = nextSteal;
        mLastGnt = eGnt;
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 9'h0, 32'h0, 3'h0, 0, 0, 9'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        int          stealAt, stallCount, gntCount, n;
        bit          dbgHeld, rcr, rcw, rdr, rdw, busy;
        logic [8:0]  rca, rda;
        logic [31:0] rcwd, rdwd;
        int          pct;

        for (int i = 0; i < 128; i++) refMem[i] = 32'h0;
        modelReset();

        // Reset: outputs idle even with both requesters active
        reset = 1'b1;
        applyStimulus(1, 0, 9'h010, 32'h0, 3'h2, 1, 0, 9'h040, 32'h0);
        #2;
        checkOutput("rst_mem_rd", mem_rd, 0);
        checkOutput("rst_dbg_gnt", dbg_gnt, 0);
        checkOutput("rst_core_stall", core_stall, 0);
        checkOutput("rst_dbg_rvalid", dbg_rvalid, 0);
        checkOutput("rst_dbg_rdata", dbg_rdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("[TB] reset released");

        // Idle core: dbg write then read back
        applyStimulus(0, 0, 9'h0, 32'h0, 3'h0, 1, 1, 9'h040, 32'hDEADBEEF);
        stepCycle();
        applyStimulus(0, 0, 9'h0, 32'h0, 3'h0, 1, 0, 9'h040, 32'h0);
        stepCycle();
        checkOutput("rb_rvalid", dbg_rvalid, 1);
        checkOutput("rb_rdata", dbg_rdata, 32'hDEADBEEF);
        applyStimulus(0, 0, 9'h0, 32'h0, 3'h0, 0, 0, 9'h0, 32'h0);
        stepCycle();

        // Core and dbg together, then core stays busy while dbg waits
        applyStimulus(1, 0, 9'h010, 32'h0, 3'h2, 1, 0, 9'h080, 32'h0);
        stepCycle();
        checkOutput("collide_gnt", obsGnt, 0);
        dbgHeld    = dbg_req && !mLastGnt;
        stealAt    = 0;
        stallCount = 0;
        for (int k = 2; k <= 16; k++) begin
            applyStimulus(1, 0, 9'h010, 32'h0, 3'h2, dbgHeld, 0, 9'h080, 32'h0);
            stepCycle();
            if (obsStall && stealAt == 0) stealAt = k;
            stallCount += int'(obsStall);
            dbgHeld = dbg_req && !mLastGnt;
        end
        checkOutput("steal_cycle", stealAt, ANTI ? MAX_WAIT + 1 : 0);
        checkOutput("steal_len", stallCount, ANTI ? 1 : 0);

        // Core busy for 50 cycles with dbg re-requesting back to back
        doReset();
        gntCount   = 0;
        stallCount = 0;
        for (int k = 1; k <= 50; k++) begin
            applyStimulus(0, 1, 9'(k * 4), 32'(k), 3'h2, 1, 0, 9'h040, 32'h0);
            stepCycle();
            gntCount   += int'(obsGnt);
            stallCount += int'(obsStall);
        end
        checkOutput("busy50_gnts", gntCount, ANTI ? 5 : 0);
        checkOutput("busy50_stalls", stallCount, ANTI ? 5 : 0);
        applyStimulus(0, 0, 9'h0, 32'h0, 3'h0, 1, 0, 9'h040, 32'h0);
        stepCycle();
        checkOutput("idle_grant", obsGnt, 1);

        // MAX_WAIT=1 instance: steals alternate with core cycles, never adjacent
        doReset();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1, 0, 9'h020, 32'h0, 3'h2, 1, 0, 9'h0C0, 32'h0);
            #1;
            checkOutput("mw1_stall", core_stall1, ANTI && (k % 2 == 1));
            checkOutput("mw1_gnt", dbg_gnt1, ANTI && (k % 2 == 1));
            stepCycle();
        end

        // Async reset in the middle of a steal cycle
        n = 0;
        while (!mSteal && n < 20) begin
            applyStimulus(1, 0, 9'h024, 32'h0, 3'h2, 1, 0, 9'h0C4, 32'h0);
            stepCycle();
            n++;
        end
        applyStimulus(1, 0, 9'h024, 32'h0, 3'h2, 1, 0, 9'h0C4, 32'h0);
        #1;
        checkOutput("pre_rst_stall", core_stall, ANTI);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_stall", core_stall, 0);
        checkOutput("mid_rst_gnt", dbg_gnt, 0);
        checkOutput("mid_rst_mem_rd", mem_rd, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        applyStimulus(0, 0, 9'h0, 32'h0, 3'h0, 0, 0, 9'h0, 32'h0);
        #1;
        checkOutput("post_rst_rvalid", dbg_rvalid, 0);
        checkOutput("post_rst_stall", core_stall, 0);
        stepCycle();

        // Randomized traffic with rising core load
        dbgHeld = 1'b0;
        rdr = 0; rdw = 0; rda = '0; rdwd = '0;
        for (int i = 0; i < 400; i++) begin
            pct  = (i < 100) ? 20 : (i < 200) ? 60 : (i < 300) ? 90 : 100;
            busy = ($urandom_range(99) < pct);
            rcr  = busy && ($urandom_range(1) == 1);
            rcw  = busy && !rcr;
            rca  = 9'($urandom_range(511));
            rcwd = $urandom;
            if (!dbgHeld) begin
                rdr  = ($urandom_range(99) < 60);
                rdw  = ($urandom_range(1) == 1);
                rda  = 9'($urandom_range(127)) << 2;
                rdwd = $urandom;
            end
            applyStimulus(rcr, rcw, rca, rcwd, 3'($urandom_range(7)), rdr, rdw, rda, rdwd);
            stepCycle();
            dbgHeld = dbg_req && !mLastGnt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
